step_ctrl: RTL and testbench
============================

Name: step_ctrl

Overview:
- Single-step / free-run controller placed upstream of the single-cycle CPU.
- Conditions the raw step button: 2-FF synchroniser, then debounce FSM.
- Produces a one-cycle step_pulse that the CPU top uses as the PC/RegisterFile/DataMem write enable on the board clock.
- Supports a free-run mode with a programmable rate; stops issuing steps once the CPU reports halt (ecall/system opcode).

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive stable synchronised samples needed to accept a press or release.
- RUN_DIV, 50000000: clk cycles between automatic steps in run mode.
- CNT_W, 26: width of the debounce and run-divider counters; must hold max(DEBOUNCE_CYCLES, RUN_DIV) - 1.

Ports:
- clk  in  1  board clock.
- reset  in  1  asynchronous, active-low reset.
- btn_step_n  in  1  raw step button, active-low, asynchronous to clk, bouncy.
- run_mode  in  1  slide switch; 1 = free-run, 0 = manual step.
- halt  in  1  CPU halt indication, combinational from the current instruction.
- step_pulse  out  1  registered, high for exactly one clk cycle per step.
- step_count  out  16  number of steps issued; saturates at 16'hFFFF.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset (reset=0, asynchronous) drives all outputs to 0:
  - step_pulse=0, step_count=0, halted=0.
  - Synchroniser flops are set to 1 (button released).
  - Debounce FSM goes to IDLE; all counters are cleared.
  - Reset asserted mid-press or mid-burst aborts the operation immediately. After release, a button still held down must pass the full debounce before it counts.
- Synchronisation:
  - btn_step_n and run_mode each pass through 2 flops. All logic below uses the synchronised versions btn_s and run_s.
- Debounce FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: btn_s=0 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: btn_s=1 → IDLE. Otherwise the counter increments. When counter = DEBOUNCE_CYCLES-1 and btn_s=0 → PRESSED, and a one-cycle press event is raised.
  - PRESSED: btn_s=1 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: btn_s=0 → PRESSED. When counter = DEBOUNCE_CYCLES-1 and btn_s=1 → IDLE.
  - Holding the button produces exactly one press event; there is no auto-repeat.
- Manual mode (run_s=0):
  - A press event with halted=0 sets step_pulse in the next cycle.
  - Latency: a stable press gives step_pulse high on clk edge DEBOUNCE_CYCLES+3, counting the first edge that samples btn_step_n low as edge 0.
- Run mode (run_s=1):
  - The divider counts 0..RUN_DIV-1 and wraps. When it wraps with halted=0, step_pulse is high for the following cycle.
  - Press events are ignored in run mode; the FSM keeps tracking the button.
  - The divider is held at 0 while run_s=0, so the first automatic step comes RUN_DIV cycles after entering run mode.
- Halt:
  - halted is set on any cycle with halt=1 and is cleared only by reset.
  - While halted=1, no step_pulse is issued.
  - If halt rises in the same cycle as a pending step, the step is suppressed.
- step_count increments on every step_pulse and saturates at 16'hFFFF (no wrap).
- Mode switch: toggling run_mode between steps never produces a double pulse, because at most one step_pulse can be issued per cycle.

Optional Feature:
- Macro: STEP_BURST_EN.
- Defined:
  - Adds input port burst_sel (1 bit, synchronised with 2 flops) and parameter BURST_LEN (default 8).
  - In manual mode, a press event with burst_sel=1 issues BURST_LEN step_pulses, one every second cycle (pulse, gap, pulse, ...), counted by a burst counter.
  - halt aborts the remaining pulses.
  - Press events that arrive during a burst are ignored.
- Undefined: burst_sel does not exist and each press gives one pulse.

Decomposition:
- Package step_ctrl_pkg holds:
  - the debounce state enum (IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT);
  - the 16-bit step_count width constant;
  - the saturation value 16'hFFFF.
- Natural sub-module: btn_debounce, containing the synchroniser and debounce FSM and emitting press_evt. step_ctrl contains the mode arbitration, divider, halt logic and counter.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=10):
- Clean press: hold btn_step_n low 20 cycles → exactly one step_pulse at edge 7; step_count=1.
- Bounce: toggle btn_step_n every 2 cycles for 12 cycles, then release → no step_pulse; step_count=0; FSM back in IDLE.
- Run mode: run_mode=1 for 45 cycles → 4 step_pulses spaced 10 cycles apart; pressing the button during this window adds none.
- Halt: in run mode, assert halt for 1 cycle after the 2nd pulse → halted=1, no further pulses; only reset=0 clears it (step_count=0 after reset).
- Saturation and reset: preload near the limit via 65535 forced steps; one more step → step_count stays at 16'hFFFF. Assert reset mid-PRESS_WAIT → all outputs 0 immediately.
- STEP_BURST_EN: burst_sel=1, press → 8 pulses on alternating cycles, step_count=8. Repeat with halt raised after the 3rd pulse → step_count=3.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared types and constants for the single-step controller.
//   db_state_e   : debounce FSM state encoding
//   STEP_CNT_W   : width of the step counter
//   STEP_CNT_MAX : saturation value of the step counter
//   sat_inc()    : saturating increment of the step counter
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int STEP_CNT_W = 16;
  localparam logic [STEP_CNT_W-1:0] STEP_CNT_MAX = 16'hFFFF;

  // Increment that sticks at STEP_CNT_MAX instead of wrapping.
  function automatic logic [STEP_CNT_W-1:0] sat_inc(input logic [STEP_CNT_W-1:0] v);
    logic [STEP_CNT_W-1:0] r;
    if (v == STEP_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/step_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser and debounce FSM for the active-low step button.
// Ports:
//   clk        in  board clock
//   reset      in  asynchronous active-low reset
//   btn_step_n in  raw, bouncy, asynchronous button (0 = pressed)
//   press_evt  out registered one-cycle pulse when a press is accepted
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_step_n,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta_r;
  logic             btn_s_r;
  db_state_e        state_r;
  db_state_e        state_n;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n;
  logic             press_n;

  // Synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_r <= 1'b1;
      btn_s_r    <= 1'b1;
    end else begin
      btn_meta_r <= btn_step_n;
      btn_s_r    <= btn_meta_r;
    end
  end

  // Debounce state, counter and press event registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      press_evt <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      press_evt <= press_n;
    end
  end

  // Debounce next-state logic: a level must be stable for DEBOUNCE_CYCLES samples.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    press_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (!btn_s_r) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (btn_s_r) begin
          state_n = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_n = PRESSED;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      PRESSED: begin
        // Held button stays here: one event per press, no auto-repeat.
        if (btn_s_r) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else begin
          state_n = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (!btn_s_r) begin
          state_n = PRESSED;
        end else if (cnt_r == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: single-step / free-run controller in front of the single-cycle CPU.
// Optional feature macro: STEP_BURST_EN (adds burst_sel input and BURST_LEN parameter).
// Ports:
//   clk        in  board clock
//   reset      in  asynchronous active-low reset
//   btn_step_n in  raw step button, active-low, bouncy
//   run_mode   in  1 = free-run, 0 = manual step
//   halt       in  CPU halt indication (same clock domain)
//   burst_sel  in  (STEP_BURST_EN only) 1 = a press issues a burst of BURST_LEN steps
//   step_pulse out registered one-cycle step strobe
//   step_count out number of steps issued, saturating at 16'hFFFF
//   halted     out sticky halt flag
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int RUN_DIV         = 50000000,
`ifdef STEP_BURST_EN
  parameter int BURST_LEN       = 8,
`endif
  parameter int CNT_W           = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_step_n,
  input  logic                  run_mode,
  input  logic                  halt,
`ifdef STEP_BURST_EN
  input  logic                  burst_sel,
`endif
  output logic                  step_pulse,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  halted
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIV - 1);

  logic             press_evt_s;
  logic             run_meta_r;
  logic             run_s_r;
  logic [CNT_W-1:0] div_r;
  logic             div_wrap_s;
  logic             halted_r;
  logic             step_req_s;
  logic             step_next_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db (
    .clk       (clk),
    .reset     (reset),
    .btn_step_n(btn_step_n),
    .press_evt (press_evt_s)
  );

  // Mode switch synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_meta_r <= 1'b0;
      run_s_r    <= 1'b0;
    end else begin
      run_meta_r <= run_mode;
      run_s_r    <= run_meta_r;
    end
  end

  assign div_wrap_s = run_s_r && (div_r == DIV_LAST);

  // Run-rate divider; parked at 0 in manual mode so run mode starts a full period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r <= '0;
    end else if (!run_s_r || div_wrap_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + CNT_W'(1);
    end
  end

`ifdef STEP_BURST_EN
  localparam int BL_W = $clog2(BURST_LEN + 1);

  logic            bsel_meta_r;
  logic            bsel_s_r;
  logic [BL_W-1:0] burst_left_r;
  logic [BL_W-1:0] burst_left_n;
  logic            gap_r;
  logic            gap_n;
  logic            burst_step_s;
  logic            manual_req_s;

  // Burst select synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bsel_meta_r <= 1'b0;
      bsel_s_r    <= 1'b0;
    end else begin
      bsel_meta_r <= burst_sel;
      bsel_s_r    <= bsel_meta_r;
    end
  end

  // Burst bookkeeping: remaining pulses and the pulse/gap phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_left_r <= '0;
      gap_r        <= 1'b0;
    end else begin
      burst_left_r <= burst_left_n;
      gap_r        <= gap_n;
    end
  end

  // Step arbitration with bursts; an active burst swallows new press events.
  always_comb begin
    burst_left_n = burst_left_r;
    gap_n        = gap_r;
    burst_step_s = 1'b0;
    manual_req_s = 1'b0;
    if (halt || halted_r) begin
      burst_left_n = '0;
      gap_n        = 1'b0;
    end else if (burst_left_r != '0) begin
      if (gap_r) begin
        gap_n = 1'b0;
      end else begin
        burst_step_s = 1'b1;
        burst_left_n = burst_left_r - BL_W'(1);
        gap_n        = 1'b1;
      end
    end else if (!run_s_r && press_evt_s) begin
      if (bsel_s_r) begin
        burst_step_s = 1'b1;
        burst_left_n = BL_W'(BURST_LEN - 1);
        gap_n        = 1'b1;
      end else begin
        manual_req_s = 1'b1;
      end
    end else begin
      gap_n = 1'b0;
    end
    if (run_s_r) begin
      step_req_s = div_wrap_s || burst_step_s;
    end else begin
      step_req_s = manual_req_s || burst_step_s;
    end
    // Live halt suppresses a step that is due in the same cycle.
    step_next_s = step_req_s && !halted_r && !halt;
  end
`else
  // Step arbitration: divider in run mode, debounced press in manual mode.
  always_comb begin
    if (run_s_r) begin
      step_req_s = div_wrap_s;
    end else begin
      step_req_s = press_evt_s;
    end
    // Live halt suppresses a step that is due in the same cycle.
    step_next_s = step_req_s && !halted_r && !halt;
  end
`endif

  // Output registers: step strobe, saturating counter and sticky halt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_pulse <= 1'b0;
      step_count <= '0;
      halted_r   <= 1'b0;
    end else begin
      step_pulse <= step_next_s;
      if (step_next_s) begin
        step_count <= sat_inc(step_count);
      end else begin
        step_count <= step_count;
      end
      halted_r <= halted_r || halt;
    end
  end

  assign halted = halted_r;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed self-checking bench for step_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=10).
// A second instance with RUN_DIV=1 steps every cycle to reach counter saturation quickly.
module tb_step_ctrl;
  import step_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_step_n = 1'b1;
  logic        run_mode = 1'b0;
  logic        halt = 1'b0;
  logic        step_pulse;
  logic        halted;
  logic [15:0] step_count;
`ifdef STEP_BURST_EN
  logic        burst_sel = 1'b0;
`endif

  logic        btn2 = 1'b1;
  logic        run_mode2 = 1'b0;
  logic        halt2 = 1'b0;
  logic        step_pulse2;
  logic        halted2;
  logic [15:0] step_count2;

  int total = 0;
  int bad = 0;
  int edges[$];

  always #5 clk = ~clk;

  step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(10), .CNT_W(26)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_step_n(btn_step_n),
    .run_mode  (run_mode),
    .halt      (halt),
`ifdef STEP_BURST_EN
    .burst_sel (burst_sel),
`endif
    .step_pulse(step_pulse),
    .step_count(step_count),
    .halted    (halted)
  );

  step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1), .CNT_W(26)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .btn_step_n(btn2),
    .run_mode  (run_mode2),
    .halt      (halt2),
`ifdef STEP_BURST_EN
    .burst_sel (1'b0),
`endif
    .step_pulse(step_pulse2),
    .step_count(step_count2),
    .halted    (halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Records the index of every edge (0-based from the call) after which step_pulse is high.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (step_pulse === 1'b1) edges.push_back(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    btn_step_n = 1'b1;
    run_mode = 1'b0;
    halt = 1'b0;
    run_mode2 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int extra;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_count", step_count, 0);
    chk("rst_halted", halted, 0);

    // Clean press: pulse on edge 7, exactly once
    do_reset();
    btn_step_n = 1'b0;
    edges.delete();
    watch(20);
    btn_step_n = 1'b1;
    chk("press_num", edges.size(), 1);
    chk("press_edge", (edges.size() > 0) ? edges[0] : -1, 7);
    chk("press_count", step_count, 1);
    repeat (10) @(negedge clk);

    // Bounce: 2-cycle toggles never reach the debounce threshold
    do_reset();
    edges.delete();
    fork
      watch(30);
      begin
        for (int k = 0; k < 6; k++) begin
          btn_step_n = (k % 2 == 1) ? 1'b1 : 1'b0;
          repeat (2) @(negedge clk);
        end
        btn_step_n = 1'b1;
      end
    join
    chk("bounce_num", edges.size(), 0);
    chk("bounce_count", step_count, 0);
    chk("bounce_idle", 32'(dut.u_db.state_r), 32'(IDLE));

    // Run mode: pulses at edges 11,21,31,41; a press in the window adds nothing
    do_reset();
    run_mode = 1'b1;
    edges.delete();
    fork
      watch(45);
      begin
        repeat (15) @(negedge clk);
        btn_step_n = 1'b0;
        repeat (15) @(negedge clk);
        btn_step_n = 1'b1;
      end
    join
    chk("run_num", edges.size(), 4);
    chk("run_first", (edges.size() > 0) ? edges[0] : -1, 11);
    for (int k = 1; k < edges.size(); k++) chk("run_gap", edges[k] - edges[k-1], 10);
    chk("run_count", step_count, 4);
    run_mode = 1'b0;
    repeat (10) @(negedge clk);

    // Halt after the 2nd pulse: sticky, blocks further pulses, cleared by reset only
    do_reset();
    run_mode = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (step_pulse) n++;
    end
    chk("halt_wait", n, 2);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    edges.delete();
    watch(40);
    chk("halt_num", edges.size(), 0);
    chk("halt_flag", halted, 1);
    chk("halt_count", step_count, 2);
    do_reset();
    chk("halt_clr_flag", halted, 0);
    chk("halt_clr_count", step_count, 0);

    // Halt in the same cycle as a due step suppresses it
    run_mode = 1'b1;
    edges.delete();
    watch(21);
    chk("same_first", (edges.size() > 0) ? edges[0] : -1, 11);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("same_pulse", step_pulse, 0);
    chk("same_count", step_count, 1);
    chk("same_halted", halted, 1);
    do_reset();

    // Saturation on the every-cycle instance
    run_mode2 = 1'b1;
    n = 0;
    for (int i = 0; i < 70000 && n < 65535; i++) begin
      @(negedge clk);
      if (step_pulse2) n++;
    end
    chk("sat_reach", n, 65535);
    chk("sat_val", step_count2, 32'h0000FFFF);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (step_pulse2) extra++;
    end
    chk("sat_more", extra, 4);
    chk("sat_hold", step_count2, 32'h0000FFFF);
    chk("sat_halted", halted2, 0);
    run_mode2 = 1'b0;

    // Reset mid-PRESS_WAIT clears outputs at once; held button must re-debounce
    do_reset();
    btn_step_n = 1'b0;
    repeat (12) @(negedge clk);
    btn_step_n = 1'b1;
    repeat (8) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("mid_pre_count", step_count, 1);
    chk("mid_pre_halted", halted, 1);
    btn_step_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_pre_state", 32'(dut.u_db.state_r), 32'(PRESS_WAIT));
    #2 reset = 1'b0;
    #1;
    chk("mid_count", step_count, 0);
    chk("mid_halted", halted, 0);
    chk("mid_pulse", step_pulse, 0);
    chk("mid_state", 32'(dut.u_db.state_r), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    edges.delete();
    watch(20);
    btn_step_n = 1'b1;
    chk("mid_re_num", edges.size(), 1);
    chk("mid_re_edge", (edges.size() > 0) ? edges[0] : -1, 7);
    repeat (10) @(negedge clk);

`ifdef STEP_BURST_EN
    // Burst: 8 pulses on alternating edges starting at edge 7
    do_reset();
    burst_sel = 1'b1;
    repeat (3) @(negedge clk);
    btn_step_n = 1'b0;
    edges.delete();
    watch(30);
    btn_step_n = 1'b1;
    chk("burst_num", edges.size(), 8);
    chk("burst_first", (edges.size() > 0) ? edges[0] : -1, 7);
    chk("burst_last", (edges.size() > 0) ? edges[edges.size()-1] : -1, 21);
    chk("burst_count", step_count, 8);
    repeat (10) @(negedge clk);

    // Burst aborted by halt after the 3rd pulse
    do_reset();
    repeat (3) @(negedge clk);
    btn_step_n = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      halt = 1'b0;
      if (step_pulse) begin
        n++;
        if (n == 3) halt = 1'b1;
      end
    end
    halt = 1'b0;
    btn_step_n = 1'b1;
    chk("babort_num", n, 3);
    chk("babort_count", step_count, 3);
    burst_sel = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
